// File: rtl/mem_lsu.sv
// Memory-stage load/store unit: turns the EX/MEM load or store into one SRAM-like bus
// transaction, stalls the pipeline while it runs and returns the extended load data.
module mem_lsu (
   input  logic        clk,
   input  logic        resetn,
   input  logic        exmem_mem_r,
   input  logic        exmem_mem_w,
   input  logic        mem_nop,
   input  logic [31:0] exmem_excepttype,
   input  logic        cu_flush,
   input  logic        ext_stall,
   input  logic [31:0] exmem_alu_res,
   input  logic [31:0] exmem_aligned_rt_data,
   input  logic [3:0]  mem_byte_w_en_out,
   input  logic [2:0]  exmem_load_sel,
   output logic        data_req,
   output logic        data_wr,
   output logic [1:0]  data_size,
   output logic [31:0] data_addr,
   output logic [31:0] data_wdata,
   output logic [3:0]  data_wstrb,
   input  logic        data_addr_ok,
   input  logic        data_data_ok,
   input  logic [31:0] data_rdata,
   output logic        lsu_stall,
   output logic [31:0] load_data,
   output logic        load_valid
);
   // state | meaning
   // IDLE  | no transaction; latch a new access from EX/MEM
   // REQ   | data_req high until the bus accepts the address
   // WAIT  | address accepted, waiting for data_data_ok
   // DONE  | result presented, pipeline released; hold while ext_stall
   typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

   state_t      state;
   logic        cancel;
   logic [31:0] addr_q;
   logic [31:0] wdata_q;
   logic [3:0]  wstrb_q;
   logic        wr_q;
   logic [2:0]  sel_q;
   logic [1:0]  size_q;
   logic        access;
   logic [1:0]  size_d;
   logic [7:0]  byte_sel;
   logic [15:0] half_sel;
   logic [31:0] ext_data;

   assign access = (exmem_mem_r | exmem_mem_w) & ~mem_nop &
                   (exmem_excepttype == 32'd0) & ~cu_flush;

   always_comb begin
      size_d = 2'd2;
      if (exmem_mem_w) begin
         case ($countones(mem_byte_w_en_out))
            1:       size_d = 2'd0;
            2:       size_d = 2'd1;
            default: size_d = 2'd2;
         endcase
      end else begin
         case (exmem_load_sel)
            3'd1, 3'd2: size_d = 2'd0;
            3'd3, 3'd4: size_d = 2'd1;
            default:    size_d = 2'd2;
         endcase
      end
   end

   always_comb begin
      byte_sel = data_rdata[7:0];
      case (addr_q[1:0])
         2'd0: byte_sel = data_rdata[7:0];
         2'd1: byte_sel = data_rdata[15:8];
         2'd2: byte_sel = data_rdata[23:16];
         2'd3: byte_sel = data_rdata[31:24];
      endcase
      half_sel = addr_q[1] ? data_rdata[31:16] : data_rdata[15:0];
      case (sel_q)
         3'd1:    ext_data = {{24{byte_sel[7]}}, byte_sel};
         3'd2:    ext_data = {24'd0, byte_sel};
         3'd3:    ext_data = {{16{half_sel[15]}}, half_sel};
         3'd4:    ext_data = {16'd0, half_sel};
         default: ext_data = data_rdata;
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state      <= IDLE;
         cancel     <= 1'b0;
         addr_q     <= 32'd0;
         wdata_q    <= 32'd0;
         wstrb_q    <= 4'd0;
         wr_q       <= 1'b0;
         sel_q      <= 3'd0;
         size_q     <= 2'd0;
         load_data  <= 32'd0;
         load_valid <= 1'b0;
      end else begin
         case (state)
            IDLE: if (access) begin
               addr_q  <= exmem_alu_res;
               wdata_q <= exmem_aligned_rt_data;
               wstrb_q <= mem_byte_w_en_out;
               wr_q    <= exmem_mem_w;
               sel_q   <= exmem_load_sel;
               size_q  <= size_d;
               state   <= REQ;
            end
            REQ: begin
               // the request is never withdrawn; a flush only marks it cancelled
               if (cu_flush) cancel <= 1'b1;
               if (data_addr_ok) state <= WAIT;
            end
            WAIT: begin
               if (data_data_ok) begin
                  if (cancel | cu_flush) begin
                     cancel <= 1'b0;
                     state  <= IDLE;
                  end else begin
                     if (!wr_q) load_data <= ext_data;
                     load_valid <= ~wr_q;
                     state      <= DONE;
                  end
               end else if (cu_flush) begin
                  cancel <= 1'b1;
               end
            end
            DONE: if (cu_flush | ~ext_stall) begin
               load_valid <= 1'b0;
               state      <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign data_req   = (state == REQ);
   assign data_wr    = wr_q;
   assign data_size  = size_q;
   assign data_addr  = addr_q;
   assign data_wdata = wdata_q;
   assign data_wstrb = wr_q ? wstrb_q : 4'd0;
   // gated by resetn so the stall reads 0 during reset even with an access pending
   assign lsu_stall  = resetn & (((state == IDLE) & access) | (state == REQ) | (state == WAIT));
endmodule

// File: tb/tb_mem_lsu.sv
// Bench for mem_lsu: directed bus scenarios plus randomized loads/stores against
// an arithmetic model of size selection and load extension.
module tb_mem_lsu;
   logic        clk = 1'b0;
   logic        resetn;
   logic        exmem_mem_r, exmem_mem_w, mem_nop, cu_flush, ext_stall;
   logic [31:0] exmem_excepttype, exmem_alu_res, exmem_aligned_rt_data;
   logic [3:0]  mem_byte_w_en_out;
   logic [2:0]  exmem_load_sel;
   logic        data_req, data_wr;
   logic [1:0]  data_size;
   logic [31:0] data_addr, data_wdata;
   logic [3:0]  data_wstrb;
   logic        data_addr_ok, data_data_ok;
   logic [31:0] data_rdata;
   logic        lsu_stall;
   logic [31:0] load_data;
   logic        load_valid;

   int          total = 0;
   int          bad = 0;
   logic [31:0] last_load = 32'd0;

   mem_lsu dut (
      .clk(clk), .resetn(resetn),
      .exmem_mem_r(exmem_mem_r), .exmem_mem_w(exmem_mem_w), .mem_nop(mem_nop),
      .exmem_excepttype(exmem_excepttype), .cu_flush(cu_flush), .ext_stall(ext_stall),
      .exmem_alu_res(exmem_alu_res), .exmem_aligned_rt_data(exmem_aligned_rt_data),
      .mem_byte_w_en_out(mem_byte_w_en_out), .exmem_load_sel(exmem_load_sel),
      .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
      .data_addr(data_addr), .data_wdata(data_wdata), .data_wstrb(data_wstrb),
      .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
      .lsu_stall(lsu_stall), .load_data(load_data), .load_valid(load_valid)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] ref_load(input logic [2:0] sel, input logic [1:0] a,
                                            input logic [31:0] rd);
      logic [31:0] b, h;
      b = (rd >> (8 * a)) & 32'hFF;
      h = (rd >> (16 * a[1])) & 32'hFFFF;
      case (sel)
         3'd1:    return (b >= 32'h80)   ? b - 32'h100   : b;
         3'd2:    return b;
         3'd3:    return (h >= 32'h8000) ? h - 32'h10000 : h;
         3'd4:    return h;
         default: return rd;
      endcase
   endfunction

   function automatic logic [1:0] ref_size(input bit ld, input logic [2:0] sel,
                                           input logic [3:0] strb);
      int n;
      if (ld) return (sel == 3'd1 || sel == 3'd2) ? 2'd0 : (sel == 3'd3 || sel == 3'd4) ? 2'd1 : 2'd2;
      n = $countones(strb);
      return (n == 1) ? 2'd0 : (n == 2) ? 2'd1 : 2'd2;
   endfunction

   // Presents one access, plays the bus with wa address waits and wdl data waits.
   task automatic do_txn(input bit ld, input logic [2:0] sel, input logic [31:0] addr,
                         input logic [31:0] wd32, input logic [3:0] strb,
                         input logic [31:0] rd, input int wa, input int wdl);
      int stall_cnt, req_cnt, wcnt, phase;
      logic [31:0] exp_ld;
      stall_cnt = 0; req_cnt = 0; wcnt = 0; phase = 0;
      exp_ld = ld ? ref_load(sel, addr[1:0], rd) : last_load;
      @(negedge clk);
      exmem_mem_r = ld; exmem_mem_w = !ld; exmem_alu_res = addr;
      exmem_aligned_rt_data = wd32; mem_byte_w_en_out = ld ? 4'h0 : strb;
      exmem_load_sel = sel; data_rdata = rd;
      for (int c = 0; c < 40 && phase != 3; c++) begin
         #1;
         data_addr_ok = 1'b0; data_data_ok = 1'b0;
         if (phase == 2) begin
            check("done_stall", lsu_stall, 0);
            check("done_valid", load_valid, ld);
            if (ld) check("load_data", load_data, exp_ld);
            exmem_mem_r = 1'b0; exmem_mem_w = 1'b0;
            phase = 3;
         end else begin
            if (lsu_stall) stall_cnt++;
            if (phase == 0 && data_req) begin
               req_cnt++;
               if (req_cnt == 1) begin
                  check("size", data_size, ref_size(ld, sel, strb));
                  check("addr", data_addr, addr);
                  check("wr", data_wr, !ld);
                  check("wstrb", data_wstrb, ld ? 4'h0 : strb);
                  if (!ld) check("wdata", data_wdata, wd32);
               end
               if (req_cnt == wa + 1) begin
                  data_addr_ok = 1'b1;
                  phase = 1;
               end
            end else if (phase == 1) begin
               if (wcnt == wdl) begin
                  data_data_ok = 1'b1;
                  phase = 2;
               end else wcnt++;
            end
         end
         @(negedge clk);
      end
      check("txn_complete", phase, 3);
      check("stall_cycles", stall_cnt, 3 + wa + wdl);
      check("req_cycles", req_cnt, wa + 1);
      last_load = exp_ld;
      #1;
      check("hold_data", load_data, last_load);
      check("valid_drop", load_valid, 0);
   endtask

   initial begin
      logic [3:0] st;
      resetn = 1'b0; exmem_mem_r = 1'b1; exmem_mem_w = 1'b0; mem_nop = 1'b0;
      cu_flush = 1'b0; ext_stall = 1'b0; exmem_excepttype = 32'd0;
      exmem_alu_res = 32'h1234; exmem_aligned_rt_data = 32'd0; mem_byte_w_en_out = 4'd0;
      exmem_load_sel = 3'd0; data_addr_ok = 1'b0; data_data_ok = 1'b0; data_rdata = 32'd0;
      #12;
      check("rst_req", data_req, 0);     check("rst_wr", data_wr, 0);
      check("rst_size", data_size, 0);   check("rst_addr", data_addr, 0);
      check("rst_wdata", data_wdata, 0); check("rst_wstrb", data_wstrb, 0);
      check("rst_stall", lsu_stall, 0);  check("rst_ldata", load_data, 0);
      check("rst_valid", load_valid, 0);
      exmem_mem_r = 1'b0;
      @(negedge clk); resetn = 1'b1;

      // LB, LHU with two address waits, SW
      do_txn(1, 3'd1, 32'h0000_1002, 32'd0, 4'h0, 32'h1280_3456, 0, 0);
      do_txn(1, 3'd4, 32'h0000_2002, 32'd0, 4'h0, 32'h9ABC_1234, 2, 0);
      do_txn(0, 3'd0, 32'h0000_0100, 32'hDEAD_BEEF, 4'hF, 32'd0, 0, 1);

      // exception: no request, no stall
      @(negedge clk);
      exmem_mem_r = 1'b1; exmem_excepttype = 32'h10;
      for (int i = 0; i < 4; i++) begin
         #1; check("exc_req", data_req, 0); check("exc_stall", lsu_stall, 0);
         @(negedge clk);
      end
      exmem_mem_r = 1'b0; exmem_excepttype = 32'd0;

      // flush together with an access in IDLE
      exmem_mem_r = 1'b1; cu_flush = 1'b1;
      #1 check("idle_flush_stall", lsu_stall, 0);
      @(negedge clk); exmem_mem_r = 1'b0; cu_flush = 1'b0;
      #1 check("idle_flush_req", data_req, 0);

      // flush during WAIT, data_ok three cycles later
      @(negedge clk);
      exmem_mem_r = 1'b1; exmem_load_sel = 3'd0; exmem_alu_res = 32'h40; data_rdata = 32'h5555_AAAA;
      #1 check("fl_c0_stall", lsu_stall, 1);
      @(negedge clk);
      #1 check("fl_c1_req", data_req, 1); data_addr_ok = 1'b1;
      @(negedge clk);
      #1 data_addr_ok = 1'b0; cu_flush = 1'b1; exmem_mem_r = 1'b0;
      check("fl_c2_stall", lsu_stall, 1);
      @(negedge clk);
      #1 cu_flush = 1'b0; check("fl_c3_stall", lsu_stall, 1);
      @(negedge clk);
      #1 check("fl_c4_stall", lsu_stall, 1);
      @(negedge clk);
      #1 data_data_ok = 1'b1; check("fl_c5_stall", lsu_stall, 1);
      @(negedge clk);
      #1 data_data_ok = 1'b0;
      check("fl_end_stall", lsu_stall, 0); check("fl_end_valid", load_valid, 0);
      check("fl_end_req", data_req, 0);
      @(negedge clk);
      #1 check("fl_valid2", load_valid, 0); check("fl_ldata", load_data, last_load);
      do_txn(1, 3'd0, 32'h0000_0044, 32'd0, 4'h0, 32'hCAFE_F00D, 1, 2);

      // randomized loads and stores
      for (int n = 0; n < 24; n++) begin
         case ($urandom % 3)
            0:       st = 4'b0001 << ($urandom % 4);
            1:       st = ($urandom % 2) ? 4'h3 : 4'hC;
            default: st = 4'hF;
         endcase
         do_txn(bit'($urandom % 2), 3'($urandom % 8), $urandom, $urandom, st, $urandom,
                int'($urandom % 4), int'($urandom % 4));
      end

      // reset asserted while data_req is high
      @(negedge clk);
      exmem_mem_r = 1'b1; exmem_load_sel = 3'd0; exmem_alu_res = 32'h88;
      @(negedge clk); @(negedge clk);
      #1 check("mr_req_before", data_req, 1);
      resetn = 1'b0;
      #1;
      check("mr_req", data_req, 0);     check("mr_wr", data_wr, 0);
      check("mr_size", data_size, 0);   check("mr_addr", data_addr, 0);
      check("mr_wdata", data_wdata, 0); check("mr_wstrb", data_wstrb, 0);
      check("mr_stall", lsu_stall, 0);  check("mr_ldata", load_data, 0);
      check("mr_valid", load_valid, 0);
      exmem_mem_r = 1'b0; last_load = 32'd0;
      @(negedge clk); resetn = 1'b1;
      @(negedge clk);
      #1 check("post_rst_req", data_req, 0); check("post_rst_stall", lsu_stall, 0);
      do_txn(1, 3'd3, 32'h0000_0006, 32'd0, 4'h0, 32'h8001_7FFF, 0, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/mem_lsu.md
# mem_lsu

Memory-stage load/store unit. Consumes the EX/MEM pipeline register outputs and turns each valid load or store into one transaction on the SRAM-like data bus. It stalls the pipeline until the transaction completes and returns size/sign-extended load data to the MEM/WB path. It is the reading end of the EX/MEM register.

## Interface
- No parameters.
- clk  in  1  clock, rising edge.
- resetn  in  1  asynchronous, active-low reset.
- exmem_mem_r  in  1  load in MEM.
- exmem_mem_w  in  1  store in MEM.
- mem_nop  in  1  MEM slot holds a bubble.
- exmem_excepttype  in  32  non-zero: instruction excepted; no access is issued.
- cu_flush  in  1  pipeline flush this cycle.
- ext_stall  in  1  stall requested by another stage.
- exmem_alu_res  in  32  effective address.
- exmem_aligned_rt_data  in  32  lane-aligned store data.
- mem_byte_w_en_out  in  4  store byte strobes.
- exmem_load_sel  in  3  load type: 0 LW, 1 LB, 2 LBU, 3 LH, 4 LHU; 5–7 treated as LW.
- data_req  out  1  bus request.
- data_wr  out  1  1 = write.
- data_size  out  2  0 byte, 1 half, 2 word.
- data_addr  out  32  bus address.
- data_wdata  out  32  write data.
- data_wstrb  out  4  write strobes, 0 for reads.
- data_addr_ok  in  1  request accepted.
- data_data_ok  in  1  read data / write acknowledgement valid.
- data_rdata  in  32  read data.
- lsu_stall  out  1  hold IF..MEM.
- load_data  out  32  extended load result.
- load_valid  out  1  load_data belongs to the current MEM instruction.

## Operation
- access = (exmem_mem_r | exmem_mem_w) & !mem_nop & (exmem_excepttype == 0) & !cu_flush.
- FSM states: IDLE, REQ, WAIT, DONE.
- **IDLE**
  - If access: latch addr, wdata, wstrb, wr and load_sel; derive size; go to REQ.
  - Size: loads use load_sel (LW→2, LB/LBU→0, LH/LHU→1). Stores use strobe popcount (1→0, 2→1, 4→2).
- **REQ**
  - data_req = 1; address and control are driven from the latched values.
  - On data_addr_ok, go to WAIT.
  - Once raised, data_req holds until data_addr_ok, even if a flush occurs.
- **WAIT**
  - data_req = 0.
  - On data_data_ok: if not cancelled, register load_data (loads only) and go to DONE.
  - If cancelled, go to IDLE and clear the cancel flag.
- **DONE**
  - load_valid = 1 for a load; stay while ext_stall = 1.
  - Return to IDLE when ext_stall = 0.
- **Cancel**
  - cu_flush in REQ or WAIT sets the cancel flag.
  - The transaction drains to completion, and its result is never presented.
  - Flush in DONE returns to IDLE and clears load_valid.
- **Load extension**, with a = latched addr[1:0]:
  - LB/LBU take byte rdata[8a+7:8a]; LB sign-extends, LBU zero-extends.
  - LH/LHU take the half selected by a[1]; LH sign-extends, LHU zero-extends.
  - LW passes rdata through.
- Store data and strobes pass through unmodified. data_wstrb = 0 when data_wr = 0.
- **lsu_stall**
  - Asserted (combinationally) when state is IDLE and access is true, or state is REQ or WAIT.
  - Deasserted in DONE.
- Only one transaction is ever outstanding.

## Timing
- While resetn is low: state = IDLE, cancel flag = 0, and every output is 0 (data_req, data_wr, data_size, data_addr, data_wdata, data_wstrb, lsu_stall, load_data, load_valid). Reset asserted mid-transaction abandons it immediately.
- Best case, with addr_ok in the first REQ cycle and data_ok in the first WAIT cycle:
  - c0 IDLE: detect the access; stall = 1.
  - c1 REQ: req = 1 with addr_ok = 1; stall = 1.
  - c2 WAIT: data_ok = 1; stall = 1.
  - c3 DONE: load_data and load_valid are valid; stall = 0, and the pipeline advances at the c3→c4 edge.
- Latency is 3 stall cycles plus addr_ok wait cycles plus data_ok wait cycles.
- data_data_ok is honoured only in WAIT. The bus guarantees it arrives no earlier than the cycle after addr_ok.
- load_data holds its value until the next load completes or reset. load_valid drops on exit from DONE.
- Simultaneous cu_flush and access in IDLE: no access is issued.
- Simultaneous cu_flush and data_data_ok in WAIT: the result is discarded and the next state is IDLE.

## Test plan
- **LB:** addr 0x0000_1002, rdata 0x1280_3456, load_sel 1, addr_ok and data_ok with zero wait.
  - data_size = 0; stall high exactly 3 cycles; load_data = 0xFFFF_FF80 in DONE.
- **LHU:** addr 0x0000_2002, rdata 0x9ABC_1234, load_sel 4, addr_ok delayed 2 cycles.
  - data_req held high for 3 cycles; load_data = 0x0000_9ABC; stall high 5 cycles.
- **SW:** strobes 0xF, wdata 0xDEAD_BEEF, addr 0x100.
  - data_wr = 1, data_size = 2, data_wstrb = 0xF; DONE reached with load_valid = 0.
- **Exception:** exmem_excepttype = 0x10 with a load.
  - data_req never asserts; lsu_stall stays 0.
- **Flush during WAIT:** cu_flush pulses 1 cycle, data_ok arrives 3 cycles later.
  - lsu_stall stays high until data_ok; no DONE; load_valid stays 0; the next access issues normally.
- **Reset mid-REQ:** resetn low while data_req = 1.
  - All outputs read 0 asynchronously; after release, state is IDLE with no request pending.
